general: RTL and testbench
==========================

GENERAL -- requirements
Module: general

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; Producto is 2*WIDTH+1 bits wide.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 q  input  1  start request, sampled on the rising edge of clk.
REQ-005 Zero  input  1  abort request, sampled on the rising edge of clk.
REQ-006 DP_B  input  WIDTH  multiplicand operand, unsigned.
REQ-007 DP_Q  input  WIDTH  multiplier operand, unsigned.
REQ-008 ready  output  3  current FSM state code, driven directly from the state register.
REQ-009 Producto  output  2*WIDTH+1  registered unsigned product.

Function
REQ-010 The block SHALL be an unsigned shift-add multiplier: an FSM plus a datapath containing carry C (1 bit), accumulator A (WIDTH), multiplier register Qr (WIDTH), operand register Br (WIDTH) and an iteration counter.
REQ-011 State codes on ready SHALL be:
- IDLE = 000
- LOAD = 001
- ADD = 010
- SHIFT = 011
- DONE = 100
- codes 101-111 are unused and SHALL go to IDLE on the next edge.
REQ-012 IDLE SHALL go to LOAD when q=1 and Zero=0; otherwise it SHALL stay in IDLE.
REQ-013 LOAD SHALL perform C=0, A=0, Qr=DP_Q, Br=DP_B, counter=WIDTH, then go to ADD.
REQ-014 Operands SHALL be captured only in LOAD; later changes on DP_B or DP_Q SHALL NOT affect the result.
REQ-015 ADD SHALL set {C,A} = A + Br when Qr[0]=1 and leave C, A unchanged otherwise, then go to SHIFT.
REQ-016 SHIFT SHALL shift {C,A,Qr} right by one with 0 entering the MSB and decrement the counter.
REQ-017 SHIFT SHALL go to DONE when the decremented counter is 0, otherwise to ADD.
REQ-018 On the edge entering DONE, Producto SHALL load {C,A,Qr}; Producto SHALL hold that value until the next DONE entry or reset.
REQ-019 Latency: ready=100 SHALL appear exactly 2*WIDTH+1 edges after the edge that samples the start in IDLE (17 edges for WIDTH=8).
REQ-020 DONE SHALL return to IDLE on the next edge (default build; see REQ-026).
REQ-021 Zero=1 in LOAD, ADD or SHIFT SHALL force IDLE on the next edge and leave Producto unchanged.
REQ-022 In IDLE, Zero=1 SHALL take priority over q.
REQ-023 q asserted while busy (LOAD, ADD, SHIFT) SHALL be ignored.
REQ-024 Boundary cases: an operand of 0 SHALL produce Producto=0; 255*255 SHALL produce 65025 with bit 16 = 0.

Reset
REQ-025 While rst=1, state SHALL be IDLE, ready=000, Producto=0 and C, A, Qr, Br and the counter SHALL all be 0, regardless of clk. Reset asserted mid-operation SHALL abandon the operation immediately. Operation SHALL resume from IDLE on the first rising edge after rst falls.

Configuration
REQ-026 Macro GENERAL_DONE_HOLD_EN:
- When defined, DONE SHALL stay in DONE while q=1 and go to IDLE on the first edge that samples q=0.
- When undefined, DONE SHALL last exactly one cycle.
- Zero=1 in DONE SHALL force IDLE in both builds.

Verification
REQ-027 Reset, then DP_B=23, DP_Q=19, q=1 for one edge -> ready steps 001,010,011,... and reaches 100 on edge 17; Producto=437 (0_0000_0001_1011_0101).
REQ-028 DP_B=255, DP_Q=255 -> Producto=65025, bit 16=0; DP_B=0, DP_Q=200 -> Producto=0.
REQ-029 Start 23*19, then Zero=1 during the 4th cycle -> ready=000 next edge; Producto keeps its previous value.
REQ-030 Start an operation, then assert rst asynchronously mid-SHIFT -> ready=000 and Producto=0 immediately without a clock edge.
REQ-031 Hold q=1 through DONE: default build -> DONE lasts 1 cycle, then back-to-back restart; with GENERAL_DONE_HOLD_EN -> ready stays 100 until q=0.
REQ-032 Change DP_B and DP_Q during ADD/SHIFT -> Producto still equals the product of the operands captured in LOAD.

Source files
------------

// File: rtl/general.sv
// general: unsigned shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH+1 bits).
// An FSM sequences LOAD, then WIDTH rounds of ADD/SHIFT over {C,A,Qr},
// and latches the product into Producto on entry to DONE.
// Optional build macro GENERAL_DONE_HOLD_EN: DONE is held while q stays high.
// Without it, DONE lasts exactly one cycle.
//
// state | meaning
// IDLE  | waiting for q=1 with Zero=0
// LOAD  | clear C/A, capture operands, preset iteration counter
// ADD   | {C,A} += Br when Qr[0] is set
// SHIFT | shift {C,A,Qr} right, count down; last round -> DONE
// DONE  | Producto holds the finished product
module general #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               q,
   input  logic               Zero,
   input  logic [WIDTH-1:0]   DP_B,
   input  logic [WIDTH-1:0]   DP_Q,
   output logic [2:0]         ready,
   output logic [2*WIDTH:0]   Producto
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_LOAD  = 3'b001,
      S_ADD   = 3'b010,
      S_SHIFT = 3'b011,
      S_DONE  = 3'b100
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_c;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_qr;
   logic [WIDTH-1:0]  r_br;
   logic [CW-1:0]     r_cnt;

   logic [WIDTH:0]    w_sum;
   logic [CW-1:0]     w_cnt_dec;
   logic              w_last;
   logic [2*WIDTH:0]  w_shifted;

   assign w_sum     = {1'b0, r_a} + {1'b0, r_br};
   assign w_cnt_dec = r_cnt - CW'(1);
   assign w_last    = (w_cnt_dec == '0);
   // {C,A,Qr} >> 1 with a zero shifted into the top
   assign w_shifted = {1'b0, r_c, r_a, r_qr[WIDTH-1:1]};
   assign ready     = r_state;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode; Zero aborts any active state back to IDLE
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = (q && !Zero) ? S_LOAD : S_IDLE;
         S_LOAD:  w_next = Zero ? S_IDLE : S_ADD;
         S_ADD:   w_next = Zero ? S_IDLE : S_SHIFT;
         S_SHIFT: w_next = Zero ? S_IDLE : (w_last ? S_DONE : S_ADD);
`ifdef GENERAL_DONE_HOLD_EN
         S_DONE:  w_next = (q && !Zero) ? S_DONE : S_IDLE;
`else
         S_DONE:  w_next = S_IDLE;
`endif
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath; an abort leaves every register (including Producto) untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_c      <= 1'b0;
         r_a      <= '0;
         r_qr     <= '0;
         r_br     <= '0;
         r_cnt    <= '0;
         Producto <= '0;
      end else if (!Zero) begin
         case (r_state)
            S_LOAD: begin
               r_c   <= 1'b0;
               r_a   <= '0;
               r_qr  <= DP_Q;
               r_br  <= DP_B;
               r_cnt <= CW'(WIDTH);
            end
            S_ADD: begin
               if (r_qr[0]) {r_c, r_a} <= w_sum;
            end
            S_SHIFT: begin
               {r_c, r_a, r_qr} <= w_shifted;
               r_cnt            <= w_cnt_dec;
               if (w_last) Producto <= w_shifted;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_general.sv
// Testbench for general: scoreboard of expected products (plain a*b),
// monitor pops on every DONE entry; directed and random operations.
module tb_general;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           q;
   logic           Zero;
   logic [W-1:0]   DP_B;
   logic [W-1:0]   DP_Q;
   logic [2:0]     ready;
   logic [2*W:0]   Producto;

   int             errors = 0;
   int             checks = 0;
   logic [2*W:0]   exp_q[$];
   logic [2*W:0]   last_prod = '0;

   always #5 clk = ~clk;

   general #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .q        (q),
      .Zero     (Zero),
      .DP_B     (DP_B),
      .DP_Q     (DP_Q),
      .ready    (ready),
      .Producto (Producto)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compare Producto against the scoreboard on each DONE entry
   initial begin
      logic [2:0]   prev;
      logic [2*W:0] e;
      prev = 3'd0;
      forever begin
         @(negedge clk);
         if (!rst && ready == 3'd4 && prev != 3'd4) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("producto", 32'(Producto), 32'(e));
               check("producto_msb", 32'(Producto[2*W]), 32'd0);
               last_prod = e;
            end
         end
         prev = ready;
      end
   end

   // One full multiply; ready sequence expected: 1, then 2/3 alternating, DONE after 2W+1 edges
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit scramble, input bit keep_q);
      int           n;
      bit           seq_ok;
      logic [2:0]   exp_r;
      logic [2*W:0] p;
      @(negedge clk);
      DP_B = a; DP_Q = b; q = 1'b1; Zero = 1'b0;
      p = (2*W+1)'(a) * (2*W+1)'(b);
      exp_q.push_back(p);
      @(posedge clk);
      @(negedge clk);
      if (!keep_q) q = 1'b0;
      check("ready_load", 32'(ready), 32'd1);
      n = 0;
      seq_ok = 1'b1;
      while (ready != 3'd4 && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (scramble) begin
            DP_B = W'($urandom);
            DP_Q = W'($urandom);
         end
         exp_r = (n >= 2*W+1) ? 3'd4 : ((n % 2) == 1 ? 3'd2 : 3'd3);
         if (ready !== exp_r) seq_ok = 1'b0;
      end
      check("latency", 32'(n), 32'(2*W+1));
      check("ready_seq", 32'(seq_ok), 32'd1);
   endtask

   initial begin
      rst = 1'b1; q = 1'b0; Zero = 1'b0; DP_B = '0; DP_Q = '0;
      #3;
      check("reset_ready", 32'(ready), 32'd0);
      check("reset_prod", 32'(Producto), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op(8'd23, 8'd19, 1'b0, 1'b0);
      check("prod_23x19", 32'(Producto), 32'd437);
      @(negedge clk);
      check("done_one_cycle", 32'(ready), 32'd0);

      run_op(8'd255, 8'd255, 1'b0, 1'b0);
      check("prod_255x255", 32'(Producto), 32'd65025);
      run_op(8'd0, 8'd200, 1'b0, 1'b0);
      check("prod_0x200", 32'(Producto), 32'd0);
      run_op(8'd200, 8'd0, 1'b0, 1'b0);
      run_op(8'd23, 8'd19, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++)
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

      // Zero has priority over q in IDLE
      @(negedge clk);
      q = 1'b1; Zero = 1'b1;
      @(negedge clk);
      check("zero_priority", 32'(ready), 32'd0);
      q = 1'b0; Zero = 1'b0;

      // Abort in the 4th busy cycle (second ADD)
      @(negedge clk);
      DP_B = 8'd23; DP_Q = 8'd19; q = 1'b1;
      @(posedge clk);
      @(negedge clk);
      q = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_pre_state", 32'(ready), 32'd2);
      Zero = 1'b1;
      @(negedge clk);
      Zero = 1'b0;
      check("abort_ready", 32'(ready), 32'd0);
      check("abort_prod_kept", 32'(Producto), 32'(last_prod));
      repeat (3) @(negedge clk);
      check("abort_stays_idle", 32'(ready), 32'd0);

      // q held through the whole operation and DONE
      run_op(8'd12, 8'd34, 1'b0, 1'b1);
`ifdef GENERAL_DONE_HOLD_EN
      repeat (3) begin
         @(negedge clk);
         check("done_hold", 32'(ready), 32'd4);
      end
      q = 1'b0;
      @(negedge clk);
      check("done_release", 32'(ready), 32'd0);
`else
      exp_q.push_back((2*W+1)'(12 * 34));
      @(negedge clk);
      check("held_q_idle", 32'(ready), 32'd0);
      @(negedge clk);
      check("held_q_restart", 32'(ready), 32'd1);
      q = 1'b0;
      begin
         int n;
         n = 0;
         while (ready != 3'd4 && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("restart_done", 32'(ready), 32'd4);
      end
`endif

      // Asynchronous reset mid-SHIFT
      @(negedge clk);
      q = 1'b0;
      @(negedge clk);
      DP_B = 8'd100; DP_Q = 8'd3; q = 1'b1;
      @(posedge clk);
      @(negedge clk);
      q = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_reset_shift", 32'(ready), 32'd3);
      #2 rst = 1'b1;
      #1;
      check("async_rst_ready", 32'(ready), 32'd0);
      check("async_rst_prod", 32'(Producto), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_prod = '0;

      run_op(8'd7, 8'd9, 1'b0, 1'b0);
      check("prod_after_reset", 32'(Producto), 32'd63);

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
